floo_credit_link_mux: RTL and testbench



---
 rtl/floo_pkg.sv | 23 ++
 rtl/floo_credit_link_mux_if.sv | 31 +++
 rtl/floo_credit_counter.sv | 34 +++
 rtl/floo_credit_link_mux.sv | 116 +++++++++++
 tb/tb_floo_credit_link_mux.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/floo_pkg.sv
// Shared helpers for the credit-based FlooNoC link multiplexer.
package floo_pkg;

  localparam logic [0:0] StUnlocked = 1'b0;
  localparam logic [0:0] StLocked   = 1'b1;

  function automatic int unsigned chan_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

  // (base + off) mod n without a divider; valid for base < n and off <= n.
  function automatic int unsigned chan_idx(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/floo_credit_link_mux_if.sv
// Channel-side and link-side signals of floo_credit_link_mux, bundled as one interface.
interface floo_credit_link_mux_if #(
  parameter int unsigned NumChannels = 3,
  parameter int unsigned FlitWidth   = 64,
  parameter int unsigned NumCredits  = 4
);
  localparam int unsigned ChanIdxW = floo_pkg::chan_idx_w(NumChannels);
  localparam int unsigned CntW     = floo_pkg::cnt_w(NumCredits);

  logic [NumChannels-1:0]                valid_i;
  logic [NumChannels-1:0]                ready_o;
  logic [NumChannels-1:0][FlitWidth-1:0] data_i;
  logic [NumChannels-1:0]                last_i;
  logic                                  valid_o;
  logic [FlitWidth-1:0]                  data_o;
  logic                                  last_o;
  logic [ChanIdxW-1:0]                   chan_o;
  logic [NumChannels-1:0]                credit_i;
  logic [NumChannels-1:0][CntW-1:0]      credits_o;
  logic                                  err_o;

  modport slave (
    input  valid_i, data_i, last_i, credit_i,
    output ready_o, valid_o, data_o, last_o, chan_o, credits_o, err_o
  );

  modport master (
    output valid_i, data_i, last_i, credit_i,
    input  ready_o, valid_o, data_o, last_o, chan_o, credits_o, err_o
  );
endinterface

// File: rtl/floo_credit_counter.sv
// Per-channel credit counter: starts full, saturates at NumCredits and flags overflow.
module floo_credit_counter #(
  parameter  int unsigned NumCredits = 4,
  localparam int unsigned CntW       = floo_pkg::cnt_w(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_count,
  output logic            o_nonzero,
  output logic            o_overflow
);

  logic [CntW-1:0] r_cnt;
  logic            w_full;

  assign w_full = (r_cnt == CntW'(NumCredits));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= CntW'(NumCredits);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - CntW'(1);
    end else if (i_inc && !i_dec && !w_full) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_count    = r_cnt;
  assign o_nonzero  = (r_cnt != '0);
  assign o_overflow = i_inc && !i_dec && w_full;

endmodule

// File: rtl/floo_credit_link_mux.sv
// Round-robin, credit-flow-controlled multiplexer of NumChannels logical channels onto one link.
module floo_credit_link_mux
  import floo_pkg::*;
#(
  parameter int unsigned NumChannels = 3,
  parameter int unsigned FlitWidth   = 64,
  parameter int unsigned NumCredits  = 4,
  parameter bit          LockOnBurst = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  floo_credit_link_mux_if.slave bus
);

  localparam int unsigned ChanIdxW = chan_idx_w(NumChannels);
  localparam int unsigned CntW     = cnt_w(NumCredits);

  typedef struct packed {
    logic [FlitWidth-1:0] data;
    logic                 last;
    logic [ChanIdxW-1:0]  chan;
  } link_flit_t;

  link_flit_t                       r_flit;
  logic                             r_valid;
  logic [0:0]                       r_state;
  logic [ChanIdxW-1:0]              r_lock;
  logic [ChanIdxW-1:0]              r_ptr;
  logic                             r_err;

  logic [NumChannels-1:0][CntW-1:0] w_cnt;
  logic [NumChannels-1:0]           w_nonzero;
  logic [NumChannels-1:0]           w_ovf;
  logic [NumChannels-1:0]           w_elig;
  logic [NumChannels-1:0]           w_gnt;
  logic                             w_gnt_vld;
  logic [ChanIdxW-1:0]              w_gnt_idx;

  for (genvar c = 0; c < NumChannels; c++) begin : g_cnt
    floo_credit_counter #(
      .NumCredits (NumCredits)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_inc      (bus.credit_i[c]),
      .i_dec      (w_gnt[c]),
      .o_count    (w_cnt[c]),
      .o_nonzero  (w_nonzero[c]),
      .o_overflow (w_ovf[c])
    );
  end

  // Credits returned this cycle only reach the counter at the edge, so they never make a channel eligible now.
  assign w_elig = bus.valid_i & w_nonzero;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!rst_i) begin
      if (r_state == StLocked) begin
        w_gnt_vld = w_elig[r_lock];
        w_gnt_idx = r_lock;
      end else begin
        for (int unsigned i = 0; i < NumChannels; i++) begin
          if (!w_gnt_vld && w_elig[ChanIdxW'(chan_idx(32'(r_ptr), i, NumChannels))]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = ChanIdxW'(chan_idx(32'(r_ptr), i, NumChannels));
          end
        end
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_gnt_vld) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
      r_state <= StUnlocked;
      r_lock  <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_gnt_vld;
      r_err   <= r_err | (|w_ovf);
      if (w_gnt_vld) begin
        r_flit <= '{data: bus.data_i[w_gnt_idx],
                    last: bus.last_i[w_gnt_idx],
                    chan: w_gnt_idx};
        // While locked only r_lock is granted, so this keeps the pointer at r_lock+1 for the whole burst.
        r_ptr  <= ChanIdxW'(chan_idx(32'(w_gnt_idx), 1, NumChannels));
        if (LockOnBurst && !bus.last_i[w_gnt_idx]) begin
          r_state <= StLocked;
          r_lock  <= w_gnt_idx;
        end else begin
          r_state <= StUnlocked;
        end
      end
    end
  end

  assign bus.ready_o   = w_gnt;
  assign bus.valid_o   = r_valid;
  assign bus.data_o    = r_flit.data;
  assign bus.last_o    = r_flit.last;
  assign bus.chan_o    = r_flit.chan;
  assign bus.credits_o = w_cnt;
  assign bus.err_o     = r_err;

endmodule

// File: tb/tb_floo_credit_link_mux.sv
// Directed and random checks of floo_credit_link_mux against a cycle-level behavioural model.
module tb_floo_credit_link_mux;

  localparam int unsigned N   = 3;
  localparam int unsigned FW  = 64;
  localparam int unsigned NC  = 4;
  localparam bit          LOB = 1'b1;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  floo_credit_link_mux_if #(.NumChannels(N), .FlitWidth(FW), .NumCredits(NC)) bus ();

  floo_credit_link_mux #(
    .NumChannels (N),
    .FlitWidth   (FW),
    .NumCredits  (NC),
    .LockOnBurst (LOB)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          m_cnt [N];
  int          m_ptr;
  int          m_lock;
  bit          m_valid;
  logic [63:0] m_data;
  bit          m_last;
  int          m_chan;
  bit          m_err;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_cnt[c] = NC;
    m_ptr = 0; m_lock = -1; m_valid = 0; m_data = '0; m_last = 0; m_chan = 0; m_err = 0;
  endtask

  function automatic int model_grant();
    if (rst_i) return -1;
    if (m_lock >= 0) return (bus.valid_i[m_lock] && m_cnt[m_lock] > 0) ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.valid_i[c] && m_cnt[c] > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst_i) begin
      model_reset();
      return;
    end
    m_valid = (g >= 0);
    for (int c = 0; c < N; c++) begin
      if (g == c && !bus.credit_i[c]) m_cnt[c]--;
      else if (g != c && bus.credit_i[c]) begin
        if (m_cnt[c] == NC) m_err = 1;
        else m_cnt[c]++;
      end
    end
    if (g >= 0) begin
      m_data = bus.data_i[g];
      m_last = bus.last_i[g];
      m_chan = g;
      m_ptr  = (g + 1) % N;
      m_lock = (LOB && !bus.last_i[g]) ? g : -1;
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] cr);
    bus.valid_i  = v;
    bus.last_i   = l;
    bus.credit_i = cr;
    for (int c = 0; c < N; c++) bus.data_i[c] = {$urandom(), $urandom()};
  endtask

  task automatic cycle();
    int g;
    @(negedge clk_i);
    g = model_grant();
    chk("ready_o", 64'(bus.ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
    chk("data_o", bus.data_o, m_data);
    chk("last_o", 64'(bus.last_o), 64'(m_last));
    chk("chan_o", 64'(bus.chan_o), 64'(m_chan));
    chk("err_o", 64'(bus.err_o), 64'(m_err));
    for (int c = 0; c < N; c++) chk("credits_o", 64'(bus.credits_o[c]), 64'(m_cnt[c]));
    @(posedge clk_i);
    model_update(g);
    #1;
  endtask

  task automatic refill();
    for (int k = 0; k < NC + 1; k++) begin
      logic [N-1:0] cr;
      for (int c = 0; c < N; c++) cr[c] = (m_cnt[c] < NC);
      drive('0, '0, cr);
      cycle();
    end
    drive('0, '0, '0);
  endtask

  initial begin
    rst_i = 1'b1;
    drive('0, '0, '0);
    model_reset();
    @(posedge clk_i);
    #1;
    cycle();
    cycle();
    rst_i = 1'b0;

    // All channels streaming single-flit bursts until credits run out
    for (int k = 1; k <= 13; k++) begin
      drive(3'b111, 3'b111, '0);
      cycle();
      if (k <= 12) begin
        chk("t1_valid", 64'(bus.valid_o), 64'd1);
        chk("t1_chan", 64'(bus.chan_o), 64'((k - 1) % 3));
      end else begin
        chk("t1_valid_end", 64'(bus.valid_o), 64'd0);
      end
    end
    chk("t1_ready", 64'(bus.ready_o), 64'd0);
    for (int c = 0; c < N; c++) chk("t1_credits", 64'(bus.credits_o[c]), 64'd0);
    refill();

    // Burst lock on ch1 while ch0/ch2 wait
    drive(3'b010, 3'b000, '0); cycle(); chk("t2_chan", 64'(bus.chan_o), 64'd1);
    drive(3'b111, 3'b101, '0); cycle(); chk("t2_chan", 64'(bus.chan_o), 64'd1);
    drive(3'b111, 3'b111, '0); cycle(); chk("t2_chan", 64'(bus.chan_o), 64'd1);
    drive(3'b101, 3'b111, '0); cycle(); chk("t2_chan", 64'(bus.chan_o), 64'd2);
    drive(3'b101, 3'b111, '0); cycle(); chk("t2_chan", 64'(bus.chan_o), 64'd0);
    refill();

    // Locked channel starved of credits
    for (int k = 0; k < 3; k++) begin drive(3'b001, 3'b001, '0); cycle(); end
    drive(3'b001, 3'b000, '0); cycle();
    chk("t3_cnt0", 64'(bus.credits_o[0]), 64'd0);
    for (int k = 0; k < 3; k++) begin drive(3'b111, 3'b111, '0); cycle(); end
    chk("t3_idle", 64'(bus.valid_o), 64'd0);
    drive(3'b111, 3'b111, 3'b001); cycle();
    chk("t3_idle_cr", 64'(bus.valid_o), 64'd0);
    drive(3'b111, 3'b111, '0); cycle();
    chk("t3_regrant_v", 64'(bus.valid_o), 64'd1);
    chk("t3_regrant_c", 64'(bus.chan_o), 64'd0);
    refill();

    // Grant and credit on the same edge; overflow on a full counter
    drive(3'b100, 3'b100, '0); cycle();
    drive(3'b100, 3'b100, '0); cycle();
    chk("t4_cnt2", 64'(bus.credits_o[2]), 64'd2);
    drive(3'b100, 3'b100, 3'b100); cycle();
    chk("t4_cnt2_same", 64'(bus.credits_o[2]), 64'd2);
    refill();
    drive('0, '0, 3'b010); cycle();
    chk("t4_err", 64'(bus.err_o), 64'd1);
    chk("t4_cnt1", 64'(bus.credits_o[1]), 64'd4);
    drive('0, '0, '0); cycle(); cycle();
    chk("t4_err_sticky", 64'(bus.err_o), 64'd1);

    // Reset in the middle of a ch1 burst
    drive(3'b010, 3'b000, '0); cycle();
    drive(3'b011, 3'b000, '0); cycle();
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    chk("t5_valid", 64'(bus.valid_o), 64'd0);
    chk("t5_err", 64'(bus.err_o), 64'd0);
    for (int c = 0; c < N; c++) chk("t5_credits", 64'(bus.credits_o[c]), 64'(NC));
    drive(3'b011, 3'b011, '0); cycle();
    chk("t5_chan", 64'(bus.chan_o), 64'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] v, l, cr;
      rst_i = ($urandom_range(99) == 0);
      v = N'($urandom());
      for (int c = 0; c < N; c++) begin
        l[c]  = ($urandom_range(9) < 6);
        cr[c] = (m_cnt[c] < NC) ? 1'($urandom_range(1)) : ($urandom_range(49) == 0);
      end
      drive(v, l, cr);
      cycle();
    end
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
